// File: rtl/barrido_display_if.sv
// Bus between the digit scanner and its frame source / 7-segment decoder.
// The master writes frames; the slave (scanner) drives the display side.
interface barrido_display_if #(
   parameter int N_DIGITOS = 4
);
   localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

   logic [4*N_DIGITOS-1:0] datos;
   logic [N_DIGITOS-1:0]   habilitar;
   logic                   cargar;
   logic [3:0]             Codigo_D;
   logic [N_DIGITOS-1:0]   anodo;
   logic [IW-1:0]          indice;
   logic                   fin_barrido;

   modport master (
      output datos, habilitar, cargar,
      input  Codigo_D, anodo, indice, fin_barrido
   );

   modport slave (
      input  datos, habilitar, cargar,
      output Codigo_D, anodo, indice, fin_barrido
   );
endinterface

// File: rtl/barrido_display.sv
// Time-multiplexed scanner for a common-anode 7-segment display with guard
// blanking at each digit change and double-buffered frame loading.
module barrido_display #(
   parameter int N_DIGITOS     = 4,
   parameter int DIV_REFRESCO  = 50000,
   parameter int CICLOS_GUARDA = 500
) (
   input logic             clk,
   input logic             reset_n,
   barrido_display_if.slave bus
);
   localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
   localparam int CW = $clog2(DIV_REFRESCO);
   localparam logic [CW-1:0] CNT_MAX    = CW'(DIV_REFRESCO - 1);
   localparam logic [CW-1:0] CNT_GUARDA = CW'(CICLOS_GUARDA);
   localparam logic [IW-1:0] IDX_MAX    = IW'(N_DIGITOS - 1);

   typedef enum logic {GUARDA, ENCENDIDO} estado_t;

   estado_t                estado, estado_next;
   logic [CW-1:0]          cnt, cnt_next;
   logic [IW-1:0]          idx;
   logic [4*N_DIGITOS-1:0] buf_datos, act_datos;
   logic [N_DIGITOS-1:0]   buf_hab, act_hab;
   logic                   pendiente;
   logic                   fin_q;
   logic                   wrap, frontera;
   logic [IW+1:0]          sel;
   logic [N_DIGITOS-1:0]   anodo_c;

   assign wrap     = (cnt == CNT_MAX);
   assign frontera = wrap && (idx == IDX_MAX);

   always_comb begin
      cnt_next = wrap ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt_next;
         if (wrap) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset_n) estado <= GUARDA;
      else          estado <= estado_next;
   end

   // Next state follows the counter value being loaded, so the anodes blank
   // on the same edge that moves idx and Codigo_D to the next digit.
   always_comb begin
      estado_next = ENCENDIDO;
      if (cnt_next < CNT_GUARDA) estado_next = GUARDA;
   end

   always_comb begin
      anodo_c = '1;
      if (estado == ENCENDIDO) anodo_c[idx] = ~act_hab[idx];
   end

   // Frame buffers; a load on the boundary bypasses the pending buffer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buf_datos <= '0;
         buf_hab   <= '0;
         act_datos <= '0;
         act_hab   <= '0;
         pendiente <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         fin_q <= frontera;
         if (bus.cargar) begin
            buf_datos <= bus.datos;
            buf_hab   <= bus.habilitar;
         end
         if (frontera) begin
            pendiente <= 1'b0;
            if (bus.cargar) begin
               act_datos <= bus.datos;
               act_hab   <= bus.habilitar;
            end else if (pendiente) begin
               act_datos <= buf_datos;
               act_hab   <= buf_hab;
            end
         end else if (bus.cargar) begin
            pendiente <= 1'b1;
         end
      end
   end

   assign sel             = {idx, 2'b00};
   assign bus.Codigo_D    = act_datos[sel +: 4];
   assign bus.anodo       = anodo_c;
   assign bus.indice      = idx;
   assign bus.fin_barrido = fin_q;
endmodule

// File: tb/tb_barrido_display.sv
// Directed table plus randomized checks of barrido_display against a
// timeline-based reference model.
module tb_barrido_display;
   localparam int N   = 4;
   localparam int DIV = 8;
   localparam int CG  = 2;
   localparam int FR  = N * DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   barrido_display_if #(.N_DIGITOS(N)) bus ();

   barrido_display #(
      .N_DIGITOS(N),
      .DIV_REFRESCO(DIV),
      .CICLOS_GUARDA(CG)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: elapsed cycles since reset plus the frame contents.
   int          mt;
   logic [15:0] m_act, m_buf;
   logic [3:0]  m_acth, m_bufh;
   bit          m_pend;

   typedef struct {
      int          adv;
      logic        ld;
      logic [15:0] d;
      logic [3:0]  h;
      logic [3:0]  e_cod;
      logic [3:0]  e_an;
      logic [1:0]  e_idx;
      logic        e_fin;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rn, input logic ld, input logic [15:0] d, input logic [3:0] h);
      if (!rn) begin
         mt = 0; m_act = '0; m_buf = '0; m_acth = '0; m_bufh = '0; m_pend = 0;
      end else begin
         if (mt % FR == FR - 1) begin
            if (ld) begin
               m_act = d; m_acth = h;
            end else if (m_pend) begin
               m_act = m_buf; m_acth = m_bufh;
            end
            m_pend = 0;
         end else if (ld) begin
            m_pend = 1;
         end
         if (ld) begin
            m_buf = d; m_bufh = h;
         end
         mt++;
      end
   endtask

   task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] h);
      bus.cargar = ld;
      bus.datos = d;
      bus.habilitar = h;
      @(posedge clk);
      model_edge(reset_n, ld, d, h);
      #1;
      bus.cargar = 1'b0;
   endtask

   task automatic check_model();
      int slot_idx, cnt;
      logic [3:0] e_cod, e_an;
      logic       e_fin;
      cnt      = mt % DIV;
      slot_idx = (mt / DIV) % N;
      e_cod    = 4'((m_act >> (4 * slot_idx)) & 16'hF);
      if (cnt < CG) e_an = 4'hF;
      else          e_an = ~4'(((m_acth >> slot_idx) & 4'h1) << slot_idx);
      e_fin = (mt > 0) && (mt % FR == 0);
      chk("rnd_codigo", 16'(bus.Codigo_D), 16'(e_cod));
      chk("rnd_anodo", 16'(bus.anodo), 16'(e_an));
      chk("rnd_indice", 16'(bus.indice), 16'(slot_idx));
      chk("rnd_fin", 16'(bus.fin_barrido), 16'(e_fin));
   endtask

   initial begin
      bus.cargar = 1'b0;
      bus.datos = '0;
      bus.habilitar = '0;

      // adv, ld, datos, hab | Codigo_D, anodo, indice, fin_barrido
      tbl.push_back('{0,  1'b0, 16'h0000, 4'h0, 4'h0, 4'hF, 2'd0, 1'b0});
      tbl.push_back('{1,  1'b1, 16'h4321, 4'hF, 4'h0, 4'hF, 2'd0, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 4'h0, 4'h0, 4'hF, 2'd0, 1'b0});
      tbl.push_back('{29, 1'b0, 16'h0000, 4'h0, 4'h0, 4'hF, 2'd3, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 4'h0, 4'h1, 4'hF, 2'd0, 1'b1});
      tbl.push_back('{1,  1'b0, 16'h0000, 4'h0, 4'h1, 4'hF, 2'd0, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 4'h0, 4'h1, 4'hE, 2'd0, 1'b0});
      tbl.push_back('{6,  1'b0, 16'h0000, 4'h0, 4'h2, 4'hF, 2'd1, 1'b0});
      tbl.push_back('{2,  1'b0, 16'h0000, 4'h0, 4'h2, 4'hD, 2'd1, 1'b0});
      tbl.push_back('{1,  1'b1, 16'h9876, 4'hF, 4'h2, 4'hD, 2'd1, 1'b0});
      tbl.push_back('{5,  1'b0, 16'h0000, 4'h0, 4'h3, 4'hF, 2'd2, 1'b0});
      tbl.push_back('{1,  1'b1, 16'hABCD, 4'hF, 4'h3, 4'hF, 2'd2, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 4'h0, 4'h3, 4'hB, 2'd2, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'h4, 4'h7, 2'd3, 1'b0});
      tbl.push_back('{6,  1'b0, 16'h0000, 4'h0, 4'hD, 4'hF, 2'd0, 1'b1});
      tbl.push_back('{2,  1'b0, 16'h0000, 4'h0, 4'hD, 4'hE, 2'd0, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'hC, 4'hD, 2'd1, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'hB, 4'hB, 2'd2, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'hA, 4'h7, 2'd3, 1'b0});
      tbl.push_back('{5,  1'b0, 16'h0000, 4'h0, 4'hA, 4'h7, 2'd3, 1'b0});
      tbl.push_back('{1,  1'b1, 16'h5555, 4'h5, 4'h5, 4'hF, 2'd0, 1'b1});
      tbl.push_back('{2,  1'b0, 16'h0000, 4'h0, 4'h5, 4'hE, 2'd0, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'h5, 4'hF, 2'd1, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'h5, 4'hB, 2'd2, 1'b0});
      tbl.push_back('{8,  1'b0, 16'h0000, 4'h0, 4'h5, 4'hF, 2'd3, 1'b0});

      // Reset held for three edges
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 16'h0, 4'h0);
         chk("reset_anodo", 16'(bus.anodo), 16'hF);
         chk("reset_codigo", 16'(bus.Codigo_D), 16'h0);
         chk("reset_fin", 16'(bus.fin_barrido), 16'h0);
      end
      reset_n = 1'b1;

      for (int v = 0; v < tbl.size(); v++) begin
         for (int k = 0; k < tbl[v].adv; k++)
            tick((k == 0) ? tbl[v].ld : 1'b0, tbl[v].d, tbl[v].h);
         chk($sformatf("vec%0d_codigo", v), 16'(bus.Codigo_D), 16'(tbl[v].e_cod));
         chk($sformatf("vec%0d_anodo", v), 16'(bus.anodo), 16'(tbl[v].e_an));
         chk($sformatf("vec%0d_indice", v), 16'(bus.indice), 16'(tbl[v].e_idx));
         chk($sformatf("vec%0d_fin", v), 16'(bus.fin_barrido), 16'(tbl[v].e_fin));
      end

      // Pending load at digit 1, then a one-cycle reset at digit 2
      for (int i = 0; i < 14; i++) tick(1'b0, 16'h0, 4'h0);
      tick(1'b1, 16'h1234, 4'hF);
      for (int i = 0; i < 9; i++) tick(1'b0, 16'h0, 4'h0);
      chk("pre_reset_indice", 16'(bus.indice), 16'd2);
      reset_n = 1'b0;
      tick(1'b0, 16'h0, 4'h0);
      reset_n = 1'b1;
      chk("midrst_codigo", 16'(bus.Codigo_D), 16'h0);
      chk("midrst_anodo", 16'(bus.anodo), 16'hF);
      chk("midrst_indice", 16'(bus.indice), 16'h0);
      chk("midrst_fin", 16'(bus.fin_barrido), 16'h0);
      for (int i = 0; i < 70; i++) begin
         tick(1'b0, 16'h0, 4'h0);
         chk("discard_codigo", 16'(bus.Codigo_D), 16'h0);
         chk("discard_anodo", 16'(bus.anodo), 16'hF);
      end

      // Randomized traffic against the reference model
      reset_n = 1'b0;
      tick(1'b0, 16'h0, 4'h0);
      reset_n = 1'b1;
      check_model();
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 399) != 0);
         tick(($urandom_range(0, 11) == 0), 16'($urandom), 4'($urandom));
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/barrido_display.md
# barrido_display

Time-multiplexed scanner for an N-digit common-anode 7-segment display. It sits directly upstream of the 7-segment decoder. It holds a frame of 4-bit digit codes and cycles through the digits at a programmable refresh rate. For each digit it presents that digit's code to the decoder's `Codigo_D` input and drives the matching active-low anode. A guard interval blanks all anodes at every digit change, and new frames are double-buffered so they take effect only at a frame boundary, which prevents tearing.

## Interface
- `N_DIGITOS`, default 4: number of digits, legal range 1..8.
- `DIV_REFRESCO`, default 50000: clock cycles per digit slot, must be ≥ 2.
- `CICLOS_GUARDA`, default 500: cycles at the start of each slot with all anodes off, must be < `DIV_REFRESCO`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `datos`  in  4*N_DIGITOS  digit codes; nibble k (bits 4k+3:4k) is digit k.
- `habilitar`  in  N_DIGITOS  per-digit enable; 0 keeps that digit's anode off.
- `cargar`  in  1  one-cycle strobe that captures `datos`/`habilitar` into the pending buffer.
- `Codigo_D`  out  4  code of the currently scanned digit, to the decoder.
- `anodo`  out  N_DIGITOS  active-low anodes; at most one bit is 0.
- `indice`  out  clog2(N_DIGITOS), min 1  currently scanned digit number.
- `fin_barrido`  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Registers:
  - prescaler `cnt` (0..DIV_REFRESCO-1);
  - digit index `idx`;
  - state `estado` ∈ {GUARDA, ENCENDIDO};
  - pending buffer (`buf_datos`, `buf_hab`) plus flag `pendiente`;
  - active frame (`act_datos`, `act_hab`).
- All outputs derive from registered state only; there is no combinational path from any input to any output.
- `cnt` increments every cycle and wraps from DIV_REFRESCO-1 to 0.
  - When `cnt` wraps, `idx` advances by 1, wrapping N_DIGITOS-1 → 0.
- FSM:
  - GUARDA while `cnt` < CICLOS_GUARDA; `anodo` is all ones.
  - ENCENDIDO for the rest of the slot; `anodo[idx]` = ~`act_hab[idx]`, all other bits 1.
  - The transition GUARDA→ENCENDIDO happens when `cnt` reaches CICLOS_GUARDA.
  - The transition ENCENDIDO→GUARDA happens when `cnt` wraps.
  - If CICLOS_GUARDA = 0, the FSM never enters GUARDA after reset exits.
- `Codigo_D` = `act_datos[4*idx +: 4]`, valid during both states.
- `indice` = `idx`.
- Load handshake:
  - `cargar`=1 writes `buf_*` from the inputs and sets `pendiente`.
  - A later `cargar` before the boundary overwrites `buf_*`; last value wins.
- Frame boundary (the cycle where `cnt` = DIV_REFRESCO-1 and `idx` = N_DIGITOS-1):
  - `act_*` ← `buf_*` if `pendiente`; `pendiente` clears.
  - `fin_barrido` is registered high for the next cycle, aligned with `idx` = 0.
- `cargar` coincident with the boundary: `act_*` takes the current `datos`/`habilitar` directly, `buf_*` is also updated, and `pendiente` stays 0.
- Reset (`reset_n`=0 at an edge):
  - `cnt`=0, `idx`=0, `estado`=GUARDA, `pendiente`=0;
  - `buf_*`=0, `act_*`=0;
  - outputs: `anodo`=all ones, `Codigo_D`=0, `indice`=0, `fin_barrido`=0.
  - Reset mid-frame discards any pending frame.
  - Scanning resumes with `cnt`=0 on the first edge with `reset_n`=1.

## Timing
- Digit slot = DIV_REFRESCO cycles; frame = N_DIGITOS·DIV_REFRESCO cycles.
- `anodo` is low for DIV_REFRESCO−CICLOS_GUARDA cycles per enabled digit.
- `idx` and `Codigo_D` change on the same edge that forces `anodo` all ones (entry to GUARDA), so the decoder input never changes while an anode is lit.
- Load latency: a `cargar` at cycle t becomes visible on the first edge after the next frame boundary.
  - Worst case is one frame plus one cycle.
  - A `cargar` on the boundary cycle is visible after one cycle.
- `fin_barrido` is high for exactly 1 cycle per frame.

## Test plan
All scenarios use N_DIGITOS=4, DIV_REFRESCO=8, CICLOS_GUARDA=2 unless stated.
- **Reset:** hold `reset_n`=0 for 3 cycles, then release → `anodo`=4'b1111 and `Codigo_D`=0 throughout reset. After release, cycles 0–1 have `anodo`=1111 and `indice` stays 0 (`act_hab` is 0, so `anodo` remains 1111 during ENCENDIDO).
- **Scan:** `cargar` with `datos`=16'h4321, `habilitar`=4'b1111 → after the next boundary, `Codigo_D` sequence is 1,2,3,4 with 8 cycles each. `anodo` within each slot: 2 cycles of 1111, then 6 cycles of 1110 / 1101 / 1011 / 0111. `fin_barrido` pulses every 32 cycles.
- **Mid-frame load:** while 16'h4321 is displayed, pulse `cargar` with 16'h9876 at digit 1. Pulse again with 16'hABCD at digit 2 → remainder of the frame still shows 3,4; the next frame shows D,C,B,A; 9876 never appears.
- **Boundary coincidence:** `cargar` with 16'h5555 exactly on the boundary cycle → digit 0 of the immediately following slot shows 5.
- **Blanking:** `habilitar`=4'b0101 → `anodo` stays 1111 during digits 1 and 3. Digits 0 and 2 light normally.
- **Reset mid-operation:** with `cargar` pending, pulse `reset_n`=0 for 1 cycle at digit 2 → all registers are zeroed, and the pending frame is never shown.
